ex_alu_rs: RTL and testbench
============================

// Module: ex_alu_rs
// PURPOSE
//  ALU reservation station: the stage directly upstream of the ALU execute unit. Holds up to DEPTH
//  dispatched ALU ops and snoops the writeback bus to wake pending operand/destination tags.
//  Each cycle it issues at most one fully-unlocked op to the ALU inputs (busy/op/tags/data/target/pc).
//  A taken jump from the ALU flushes every held op.
// PARAMETERS
//  DEPTH    4   entries held; power of two, 2..16
//  TAG_W    4   regtag_t width; tag value `UNLOCKED (all ones) means "no dependency"
//  OP_W     6   sinst_t width
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous active-low reset
//  disp_en_in     in   1      allocator presents an op this cycle
//  disp_op_in     in   OP_W   ALU opcode
//  disp_pc_in     in   32     instruction pc
//  disp_tagx_in   in   TAG_W  operand-x tag
//  disp_tagy_in   in   TAG_W  operand-y tag
//  disp_tagw_in   in   TAG_W  destination-lock tag
//  disp_datax_in  in   32     operand-x value, valid when tagx unlocked
//  disp_datay_in  in   32     operand-y value, valid when tagy unlocked
//  disp_target_in in   5      destination register
//  rs_full_out    out  1      no free entry; allocator must not dispatch
//  wb_en_in       in   1      writeback broadcast valid
//  wb_tag_in      in   TAG_W  tag being retired
//  wb_data_in     in   32     retired value
//  flush_in       in   1      taken jump (ALU en_jmp): discard all entries
//  alu_busy_out   out  1      issued op valid to ALU
//  alu_op_out / alu_pc_out / alu_tagx_out / alu_tagy_out / alu_tagw_out / alu_datax_out /
//  alu_datay_out / alu_target_out   out   widths as dispatch   issued op fields
// BEHAVIOUR
//  - Reset: all entries invalid; rs_full_out=0, alu_busy_out=0, all alu_* tags=`UNLOCKED, data/pc/op=0.
//  - Entry state: valid, op, pc, target, tagx/y/w, datax/y. Ready = valid & all three tags `UNLOCKED.
//  - Dispatch: written into the lowest-index free entry at the clock edge. Same-cycle wakeup
//    bypass: a field whose tag equals wb_tag_in while wb_en_in=1 is stored already unlocked
//    (datax/datay take wb_data_in; tagw only unlocks).
//  - Wakeup: for every valid entry, each tag equal to wb_tag_in while wb_en_in=1 becomes `UNLOCKED,
//    capturing wb_data_in into the matching data field. wb_tag_in==`UNLOCKED is ignored.
//  - Issue: selects the lowest-index entry that is ready in REGISTERED state (wakeup counts from
//    the next cycle). Selected fields are registered onto alu_* with alu_busy_out=1 for exactly one
//    cycle, and the entry is freed at that edge. No ready entry -> alu_busy_out=0 next cycle.
//    Latency: dispatch of an unlocked op -> alu_busy_out=1 two edges later; wakeup -> issue two edges later.
//  - Issued tags are always `UNLOCKED, so the ALU executes on the cycle it sees busy; no back-pressure.
//  - rs_full_out is combinational from registered valid bits (all valid). Freeing and dispatch in
//    the same cycle are both performed; a freed slot is not reusable in the cycle it is freed.
//    Dispatch while full is a protocol violation (bench asserts); the op is dropped, state unchanged.
//  - Flush: at the edge with flush_in=1 all entries become invalid and alu_busy_out is 0 next cycle.
//    Dispatch, wakeup and issue in that cycle are discarded. Flush has priority over everything.
//  - Async reset mid-operation: state returns to reset values immediately; no partial issue survives.
// STRUCTURE
//  - Shared package/defines: `UNLOCKED, regtag_t, sinst_t, word_t, addr_t, regaddr_t widths.
//  - Sub-module rs_pick_lowest: parameterised priority encoder (DEPTH-bit mask -> index + found).
//    Used for both free-slot select and ready select.
// TESTING
//  1 Reset: rst_n=0 mid-run with 3 valid -> alu_busy_out=0, rs_full_out=0, tags `UNLOCKED immediately.
//  2 Dispatch ADD, tags unlocked, x=5, y=7 -> alu_busy_out=1 two edges later, datax=5, datay=7, then 0.
//  3 Dispatch SUB, tagx=3 -> no issue; wb_en tag=3 data=0x10 -> issue next cycle, datax=0x10.
//  4 Same-cycle bypass: dispatch tagy=2 with wb_en tag=2 data=9 -> issues 2 edges later with datay=9.
//  5 Fill 4 entries, all locked -> rs_full_out=1; wake entry 2 -> issues; full drops after free edge;
//    two ready entries 0 and 3 -> 0 issues first, 3 next cycle.
//  6 Flush with 3 valid plus dispatch/wb same cycle -> all invalid, no issue, rs_full_out=0.

Source files
------------

// File: rtl/ex_alu_rs_pkg.sv
// ALU reservation station shared types, widths and the tag-match helper.
// Imported by the interface, the picker and the station top.
package ex_alu_rs_pkg;

   localparam int RS_DEPTH = 4;
   localparam int TAG_W    = 4;
   localparam int OP_W     = 6;

   typedef logic [TAG_W-1:0] regtag_t;
   typedef logic [OP_W-1:0]  sinst_t;
   typedef logic [31:0]      word_t;
   typedef logic [31:0]      addr_t;
   typedef logic [4:0]       regaddr_t;

   // All-ones tag means the field carries no dependency.
   localparam regtag_t UNLOCKED = '1;

   typedef struct packed {
      logic     valid;
      sinst_t   op;
      addr_t    pc;
      regaddr_t target;
      regtag_t  tagx;
      regtag_t  tagy;
      regtag_t  tagw;
      word_t    datax;
      word_t    datay;
   } rs_entry_t;

   // A broadcast of UNLOCKED never matches: it would wake nothing.
   function automatic logic wb_hit(
      input regtag_t t,
      input logic    en,
      input regtag_t wt
   );
      return en && (wt != UNLOCKED) && (t == wt);
   endfunction

endpackage

// File: rtl/ex_alu_rs_if.sv
// Dispatch, writeback, flush and issue bundle of the ALU reservation station.
// slave: station side; master: allocator/ALU/bench side.
interface ex_alu_rs_if;
   import ex_alu_rs_pkg::*;

   logic     disp_en_in;
   sinst_t   disp_op_in;
   addr_t    disp_pc_in;
   regtag_t  disp_tagx_in;
   regtag_t  disp_tagy_in;
   regtag_t  disp_tagw_in;
   word_t    disp_datax_in;
   word_t    disp_datay_in;
   regaddr_t disp_target_in;
   logic     rs_full_out;
   logic     wb_en_in;
   regtag_t  wb_tag_in;
   word_t    wb_data_in;
   logic     flush_in;
   logic     alu_busy_out;
   sinst_t   alu_op_out;
   addr_t    alu_pc_out;
   regtag_t  alu_tagx_out;
   regtag_t  alu_tagy_out;
   regtag_t  alu_tagw_out;
   word_t    alu_datax_out;
   word_t    alu_datay_out;
   regaddr_t alu_target_out;

   modport slave (
      input  disp_en_in, disp_op_in, disp_pc_in,
      input  disp_tagx_in, disp_tagy_in, disp_tagw_in,
      input  disp_datax_in, disp_datay_in, disp_target_in,
      input  wb_en_in, wb_tag_in, wb_data_in, flush_in,
      output rs_full_out,
      output alu_busy_out, alu_op_out, alu_pc_out,
      output alu_tagx_out, alu_tagy_out, alu_tagw_out,
      output alu_datax_out, alu_datay_out, alu_target_out
   );

   modport master (
      output disp_en_in, disp_op_in, disp_pc_in,
      output disp_tagx_in, disp_tagy_in, disp_tagw_in,
      output disp_datax_in, disp_datay_in, disp_target_in,
      output wb_en_in, wb_tag_in, wb_data_in, flush_in,
      input  rs_full_out,
      input  alu_busy_out, alu_op_out, alu_pc_out,
      input  alu_tagx_out, alu_tagy_out, alu_tagw_out,
      input  alu_datax_out, alu_datay_out, alu_target_out
   );

endinterface

// File: rtl/ex_alu_rs_pick.sv
// rs_pick_lowest: priority encoder, lowest set bit of mask wins.
// Ports: mask (N bits) -> idx (index of lowest set bit), found (any set).
module rs_pick_lowest #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scanning downward lets the lowest set bit be the last writer.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (mask[i]) begin
            idx   = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ex_alu_rs.sv
// ALU reservation station: holds dispatched ops, wakes tags from writeback,
// issues one ready op per cycle. Ports: clk, rst_n, bus (ex_alu_rs_if.slave).
module ex_alu_rs
   import ex_alu_rs_pkg::*;
#(
   parameter int DEPTH = RS_DEPTH
) (
   input  logic         clk,
   input  logic         rst_n,
   ex_alu_rs_if.slave   bus
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rs_entry_t        ent [DEPTH];
   rs_entry_t        nxt;
   rs_entry_t        sel;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] ready;
   logic [IW-1:0]    free_idx;
   logic [IW-1:0]    iss_idx;
   logic             free_found;
   logic             iss_found;

   logic     alu_busy;
   sinst_t   alu_op;
   addr_t    alu_pc;
   regtag_t  alu_tagx;
   regtag_t  alu_tagy;
   regtag_t  alu_tagw;
   word_t    alu_datax;
   word_t    alu_datay;
   regaddr_t alu_target;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid[i] = ent[i].valid;
         ready[i] = ent[i].valid
                 && (ent[i].tagx == UNLOCKED)
                 && (ent[i].tagy == UNLOCKED)
                 && (ent[i].tagw == UNLOCKED);
      end
   end

   rs_pick_lowest #(.N(DEPTH), .IW(IW)) u_free (
      .mask  (~valid),
      .idx   (free_idx),
      .found (free_found)
   );

   rs_pick_lowest #(.N(DEPTH), .IW(IW)) u_iss (
      .mask  (ready),
      .idx   (iss_idx),
      .found (iss_found)
   );

   assign sel = ent[iss_idx];

   // Incoming op, with fields woken by a same-cycle broadcast.
   always_comb begin
      nxt        = '0;
      nxt.valid  = 1'b1;
      nxt.op     = bus.disp_op_in;
      nxt.pc     = bus.disp_pc_in;
      nxt.target = bus.disp_target_in;
      nxt.tagx   = bus.disp_tagx_in;
      nxt.tagy   = bus.disp_tagy_in;
      nxt.tagw   = bus.disp_tagw_in;
      nxt.datax  = bus.disp_datax_in;
      nxt.datay  = bus.disp_datay_in;
      if (wb_hit(bus.disp_tagx_in, bus.wb_en_in, bus.wb_tag_in)) begin
         nxt.tagx  = UNLOCKED;
         nxt.datax = bus.wb_data_in;
      end
      if (wb_hit(bus.disp_tagy_in, bus.wb_en_in, bus.wb_tag_in)) begin
         nxt.tagy  = UNLOCKED;
         nxt.datay = bus.wb_data_in;
      end
      if (wb_hit(bus.disp_tagw_in, bus.wb_en_in, bus.wb_tag_in)) begin
         nxt.tagw = UNLOCKED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         alu_busy   <= 1'b0;
         alu_op     <= '0;
         alu_pc     <= '0;
         alu_tagx   <= UNLOCKED;
         alu_tagy   <= UNLOCKED;
         alu_tagw   <= UNLOCKED;
         alu_datax  <= '0;
         alu_datay  <= '0;
         alu_target <= '0;
      end else if (bus.flush_in) begin
         for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
         alu_busy <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (ent[i].valid) begin
               if (wb_hit(ent[i].tagx, bus.wb_en_in, bus.wb_tag_in)) begin
                  ent[i].tagx  <= UNLOCKED;
                  ent[i].datax <= bus.wb_data_in;
               end
               if (wb_hit(ent[i].tagy, bus.wb_en_in, bus.wb_tag_in)) begin
                  ent[i].tagy  <= UNLOCKED;
                  ent[i].datay <= bus.wb_data_in;
               end
               if (wb_hit(ent[i].tagw, bus.wb_en_in, bus.wb_tag_in)) begin
                  ent[i].tagw <= UNLOCKED;
               end
            end
            if (iss_found && (iss_idx == IW'(i))) ent[i].valid <= 1'b0;
         end
         // free_found comes from registered valids, so a slot freed
         // at this edge is never the dispatch target.
         if (bus.disp_en_in && free_found) ent[free_idx] <= nxt;
         alu_busy <= iss_found;
         if (iss_found) begin
            alu_op     <= sel.op;
            alu_pc     <= sel.pc;
            alu_tagx   <= sel.tagx;
            alu_tagy   <= sel.tagy;
            alu_tagw   <= sel.tagw;
            alu_datax  <= sel.datax;
            alu_datay  <= sel.datay;
            alu_target <= sel.target;
         end
      end
   end

   assign bus.rs_full_out    = &valid;
   assign bus.alu_busy_out   = alu_busy;
   assign bus.alu_op_out     = alu_op;
   assign bus.alu_pc_out     = alu_pc;
   assign bus.alu_tagx_out   = alu_tagx;
   assign bus.alu_tagy_out   = alu_tagy;
   assign bus.alu_tagw_out   = alu_tagw;
   assign bus.alu_datax_out  = alu_datax;
   assign bus.alu_datay_out  = alu_datay;
   assign bus.alu_target_out = alu_target;

endmodule

// File: tb/tb_ex_alu_rs.sv
// Testbench for ex_alu_rs: directed scenarios plus random traffic,
// scoreboarded against a slot-level reference model.
module tb_ex_alu_rs;
   import ex_alu_rs_pkg::*;

   localparam logic [3:0] U = 4'hF;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ex_alu_rs_if bus ();

   ex_alu_rs dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          v;
      logic [5:0]  op;
      logic [31:0] pc;
      logic [31:0] x;
      logic [31:0] y;
      logic [4:0]  tg;
      logic [3:0]  tx;
      logic [3:0]  ty;
      logic [3:0]  tw;
   } m_t;

   m_t           m [4];
   logic [106:0] expq [$];
   bit           exp_busy = 1'b0;
   int           n_checks = 0;
   int           n_pass   = 0;

   task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, a, e);
   endtask

   function automatic bit model_full();
      bit f = 1'b1;
      for (int i = 0; i < 4; i++) if (!m[i].v) f = 1'b0;
      return f;
   endfunction

   function automatic bit hits(logic [3:0] t);
      return bus.wb_en_in && (bus.wb_tag_in != U) && (t == bus.wb_tag_in);
   endfunction

   // One clock edge of the station, straight from the behavioural rules.
   task automatic model_step();
      int k = -1;
      int f = -1;
      m_t n;
      if (bus.flush_in) begin
         for (int i = 0; i < 4; i++) m[i].v = 1'b0;
         exp_busy = 1'b0;
         return;
      end
      for (int i = 0; i < 4; i++)
         if (k < 0 && m[i].v && m[i].tx == U && m[i].ty == U && m[i].tw == U)
            k = i;
      for (int i = 0; i < 4; i++) if (f < 0 && !m[i].v) f = i;
      exp_busy = (k >= 0);
      if (k >= 0) begin
         expq.push_back({m[k].op, m[k].pc, m[k].x, m[k].y, m[k].tg});
         m[k].v = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
         if (m[i].v) begin
            if (hits(m[i].tx)) begin m[i].tx = U; m[i].x = bus.wb_data_in; end
            if (hits(m[i].ty)) begin m[i].ty = U; m[i].y = bus.wb_data_in; end
            if (hits(m[i].tw)) m[i].tw = U;
         end
      end
      if (bus.disp_en_in) begin
         if (f < 0) begin
            chk("disp_while_full", 1, 0);
         end else begin
            n.v  = 1'b1;
            n.op = bus.disp_op_in;
            n.pc = bus.disp_pc_in;
            n.tg = bus.disp_target_in;
            n.tx = bus.disp_tagx_in;
            n.ty = bus.disp_tagy_in;
            n.tw = bus.disp_tagw_in;
            n.x  = bus.disp_datax_in;
            n.y  = bus.disp_datay_in;
            if (hits(n.tx)) begin n.tx = U; n.x = bus.wb_data_in; end
            if (hits(n.ty)) begin n.ty = U; n.y = bus.wb_data_in; end
            if (hits(n.tw)) n.tw = U;
            m[f] = n;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", {127'd0, bus.alu_busy_out}, {127'd0, exp_busy});
         chk("full", {127'd0, bus.rs_full_out}, {127'd0, model_full()});
         if (bus.alu_busy_out) begin
            if (expq.size() == 0) begin
               chk("issue_unexpected", 1, 0);
            end else begin
               chk("issue",
                   {21'd0, bus.alu_op_out, bus.alu_pc_out, bus.alu_datax_out,
                    bus.alu_datay_out, bus.alu_target_out},
                   {21'd0, expq.pop_front()});
               chk("issue_tags",
                   {116'd0, bus.alu_tagx_out, bus.alu_tagy_out, bus.alu_tagw_out},
                   {116'd0, 12'hFFF});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      bus.disp_en_in     = 1'b0;
      bus.disp_op_in     = '0;
      bus.disp_pc_in     = '0;
      bus.disp_tagx_in   = U;
      bus.disp_tagy_in   = U;
      bus.disp_tagw_in   = U;
      bus.disp_datax_in  = '0;
      bus.disp_datay_in  = '0;
      bus.disp_target_in = '0;
      bus.wb_en_in       = 1'b0;
      bus.wb_tag_in      = U;
      bus.wb_data_in     = '0;
      bus.flush_in       = 1'b0;
   endtask

   task automatic disp(logic [5:0] op, logic [31:0] pc, logic [3:0] tx,
                       logic [3:0] ty, logic [3:0] tw, logic [31:0] dx,
                       logic [31:0] dy, logic [4:0] tg);
      bus.disp_en_in     = 1'b1;
      bus.disp_op_in     = op;
      bus.disp_pc_in     = pc;
      bus.disp_tagx_in   = tx;
      bus.disp_tagy_in   = ty;
      bus.disp_tagw_in   = tw;
      bus.disp_datax_in  = dx;
      bus.disp_datay_in  = dy;
      bus.disp_target_in = tg;
   endtask

   task automatic wb(logic [3:0] t, logic [31:0] d);
      bus.wb_en_in   = 1'b1;
      bus.wb_tag_in  = t;
      bus.wb_data_in = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", {127'd0, bus.alu_busy_out}, 0);
      chk("rst_full", {127'd0, bus.rs_full_out}, 0);
      chk("rst_tags", {116'd0, bus.alu_tagx_out, bus.alu_tagy_out,
                       bus.alu_tagw_out}, {116'd0, 12'hFFF});
      chk("rst_data", {bus.alu_datax_out, bus.alu_datay_out,
                       bus.alu_pc_out, 26'd0, bus.alu_op_out}, 0);
      for (int i = 0; i < 4; i++) m[i].v = 1'b0;
      expq.delete();
      exp_busy = 1'b0;
      idle();
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   function automatic logic [3:0] rtag();
      logic [3:0] t = U;
      if ($urandom_range(2) == 0) t = 4'($urandom_range(3));
      return t;
   endfunction

   initial begin
      idle();
      for (int i = 0; i < 4; i++) m[i].v = 1'b0;
      #2;
      do_reset();

      // Unlocked ADD: busy two edges later.
      disp(6'h01, 32'h100, U, U, U, 32'd5, 32'd7, 5'd3);
      step();
      idle();
      chk("t2_busy_early", {127'd0, bus.alu_busy_out}, 0);
      step();
      chk("t2_busy", {127'd0, bus.alu_busy_out}, 1);
      chk("t2_xy", {64'd0, bus.alu_datax_out, bus.alu_datay_out}, {64'd0, 32'd5, 32'd7});
      step();
      chk("t2_busy_drop", {127'd0, bus.alu_busy_out}, 0);

      // Locked SUB woken by writeback.
      disp(6'h02, 32'h104, 4'd3, U, U, 32'hDEAD, 32'd1, 5'd4);
      step();
      idle();
      step();
      step();
      wb(4'd3, 32'h10);
      step();
      idle();
      step();
      chk("t3_x", {96'd0, bus.alu_datax_out}, {96'd0, 32'h10});

      // Same-cycle bypass on y.
      disp(6'h03, 32'h108, U, 4'd2, U, 32'd1, 32'hBAD, 5'd5);
      wb(4'd2, 32'd9);
      step();
      idle();
      step();
      chk("t4_y", {96'd0, bus.alu_datay_out}, {96'd0, 32'd9});
      step();

      // Fill, wake entry 2, then entries 0 and 3 together.
      disp(6'h04, 32'h200, 4'd5, U, U, 1, 1, 5'd1);
      step();
      disp(6'h05, 32'h204, 4'd6, U, U, 2, 2, 5'd2);
      step();
      disp(6'h06, 32'h208, U, U, 4'd7, 3, 3, 5'd3);
      step();
      disp(6'h07, 32'h20C, U, 4'd5, U, 4, 4, 5'd4);
      step();
      idle();
      chk("t5_full", {127'd0, bus.rs_full_out}, 1);
      wb(4'd7, 32'h77);
      step();
      idle();
      step();
      chk("t5_pc2", {96'd0, bus.alu_pc_out}, {96'd0, 32'h208});
      chk("t5_full_drop", {127'd0, bus.rs_full_out}, 0);
      wb(4'd5, 32'h55);
      step();
      idle();
      step();
      chk("t5_pc0", {96'd0, bus.alu_pc_out}, {96'd0, 32'h200});
      step();
      chk("t5_pc3", {96'd0, bus.alu_pc_out}, {96'd0, 32'h20C});
      wb(4'd6, 32'h66);
      step();
      idle();
      step();
      step();

      // Flush with dispatch and writeback in the same cycle.
      for (int i = 0; i < 3; i++) begin
         disp(6'h08, 32'h300 + 32'(i * 4), 4'd1, U, U, 0, 0, 5'd6);
         step();
      end
      disp(6'h09, 32'h310, U, U, U, 0, 0, 5'd7);
      wb(4'd1, 32'h11);
      bus.flush_in = 1'b1;
      step();
      idle();
      chk("t6_full", {127'd0, bus.rs_full_out}, 0);
      chk("t6_busy", {127'd0, bus.alu_busy_out}, 0);
      step();
      step();

      // Reset mid-run with three held ops and an issue in flight.
      disp(6'h0A, 32'h400, 4'd8, U, U, 0, 0, 5'd8);
      step();
      disp(6'h0B, 32'h404, 4'd8, U, U, 0, 0, 5'd9);
      step();
      disp(6'h0C, 32'h408, U, U, U, 32'd12, 32'd13, 5'd10);
      step();
      disp(6'h0D, 32'h40C, U, 4'd8, U, 0, 0, 5'd11);
      step();
      idle();
      do_reset();
      step();

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         idle();
         if (!model_full() && $urandom_range(1) == 1)
            disp(6'($urandom), $urandom, rtag(), rtag(), rtag(),
                 $urandom, $urandom, 5'($urandom));
         if ($urandom_range(1) == 1) begin
            if ($urandom_range(4) == 0) wb(U, $urandom);
            else wb(4'($urandom_range(3)), $urandom);
         end
         bus.flush_in = ($urandom_range(39) == 0);
         step();
      end
      idle();
      step();
      step();
      bus.flush_in = 1'b1;
      step();
      idle();
      step();
      step();
      chk("drain", {96'd0, 32'(expq.size())}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
